// File: rtl/servo_pwm_if.sv
// servo_pwm_if: command inputs and pulse/status outputs of the two-channel servo pulse generator.
// The master drives the speed commands; the slave (servo_pwm) drives pulses, frame strobe and applied values.
interface servo_pwm_if;
  logic [7:0] servo_l;
  logic [7:0] servo_r;
  logic       pwm_l;
  logic       pwm_r;
  logic       frame_start;
  logic [7:0] applied_l;
  logic [7:0] applied_r;

  modport master (
    output servo_l,
    output servo_r,
    input  pwm_l,
    input  pwm_r,
    input  frame_start,
    input  applied_l,
    input  applied_r
  );

  modport slave (
    input  servo_l,
    input  servo_r,
    output pwm_l,
    output pwm_r,
    output frame_start,
    output applied_l,
    output applied_r
  );
endinterface

// File: rtl/servo_pwm.sv
// servo_pwm: two-channel servo pulse generator, one pulse per PERIOD_CYC frame, width from a per-frame command sample.
// Define SERVO_PWM_SLEW_EN to limit the applied command change to SLEW_STEP per frame.
module servo_pwm #(
  parameter int unsigned PERIOD_CYC = 2_000_000,
  parameter int unsigned MIN_CYC    = 100_000,
  parameter int unsigned STEP_CYC   = 392,
  parameter int unsigned SLEW_STEP  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  servo_pwm_if.slave bus
);

  typedef enum logic {
    ST_START,
    ST_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  applied_l_q, applied_l_d;
  logic [7:0]  applied_r_q, applied_r_d;
  logic [31:0] width_l_q, width_l_d;
  logic [31:0] width_r_q, width_r_d;
  logic        pwm_l_q, pwm_l_d;
  logic        pwm_r_q, pwm_r_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_edge;

  function automatic logic [31:0] width_of(input logic [7:0] a);
    logic [31:0] w;
    if (a == 8'd0) begin
      w = 32'd0;
    end else begin
      w = MIN_CYC + ({24'd0, a} * STEP_CYC);
    end
    return w;
  endfunction

`ifdef SERVO_PWM_SLEW_EN
  // A step larger than SLEW_STEP implies SLEW_STEP < 255, so the +/- cannot wrap.
  function automatic logic [7:0] slew_to(input logic [7:0] t, input logic [7:0] a);
    logic [7:0] diff;
    logic [7:0] r;
    diff = (t >= a) ? (t - a) : (a - t);
    if ({24'd0, diff} <= SLEW_STEP) begin
      r = t;
    end else if (t > a) begin
      r = a + SLEW_STEP[7:0];
    end else begin
      r = a - SLEW_STEP[7:0];
    end
    return r;
  endfunction
`endif

  // ST_START makes the first clock after reset a frame edge with cnt held at 0.
  always_comb begin
    state_d       = ST_RUN;
    frame_edge    = (state_q == ST_START) || (cnt_q == PERIOD_CYC - 32'd1);
    cnt_d         = frame_edge ? 32'd0 : cnt_q + 32'd1;
    applied_l_d   = applied_l_q;
    applied_r_d   = applied_r_q;
    width_l_d     = width_l_q;
    width_r_d     = width_r_q;
    frame_start_d = frame_edge;

    if (frame_edge) begin
`ifdef SERVO_PWM_SLEW_EN
      applied_l_d = slew_to(bus.servo_l, applied_l_q);
      applied_r_d = slew_to(bus.servo_r, applied_r_q);
`else
      applied_l_d = bus.servo_l;
      applied_r_d = bus.servo_r;
`endif
      width_l_d = width_of(applied_l_d);
      width_r_d = width_of(applied_r_d);
    end

    // Pulse is high while the cycle index of the coming cycle is below the width.
    pwm_l_d = (cnt_d < width_l_d);
    pwm_r_d = (cnt_d < width_r_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_START;
      cnt_q         <= 32'd0;
      applied_l_q   <= 8'd0;
      applied_r_q   <= 8'd0;
      width_l_q     <= 32'd0;
      width_r_q     <= 32'd0;
      pwm_l_q       <= 1'b0;
      pwm_r_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      applied_l_q   <= applied_l_d;
      applied_r_q   <= applied_r_d;
      width_l_q     <= width_l_d;
      width_r_q     <= width_r_d;
      pwm_l_q       <= pwm_l_d;
      pwm_r_q       <= pwm_r_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pwm_l       = pwm_l_q;
  assign bus.pwm_r       = pwm_r_q;
  assign bus.frame_start = frame_start_q;
  assign bus.applied_l   = applied_l_q;
  assign bus.applied_r   = applied_r_q;

endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: randomized and directed stimulus for servo_pwm, checked every cycle against a frame-position model.
// Build with SERVO_PWM_SLEW_EN defined to exercise the slew-limited variant.
module tb_servo_pwm;

  localparam int PERIOD = 1000;
  localparam int MIN_W  = 50;
  localparam int STEP_W = 1;
  localparam int SLEW   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  servo_pwm_if bus ();

  servo_pwm #(
    .PERIOD_CYC (PERIOD),
    .MIN_CYC    (MIN_W),
    .STEP_CYC   (STEP_W),
    .SLEW_STEP  (SLEW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_running = 1'b0;
  int m_pos     = 0;
  int m_app_l   = 0;
  int m_app_r   = 0;
  bit check_en  = 1'b0;

  bit meas_valid = 1'b0;
  int hi_l = 0, hi_r = 0;
  int exp_len_l = 0, exp_len_r = 0;

  function automatic int pulse_w(input int a);
    return (a == 0) ? 0 : MIN_W + a * STEP_W;
  endfunction

  function automatic int next_applied(input int t, input int a);
    int d;
    d = t - a;
`ifdef SERVO_PWM_SLEW_EN
    if (d > SLEW)  d = SLEW;
    if (d < -SLEW) d = -SLEW;
`endif
    return a + d;
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic applyStimulus(input int l, input int r);
    bus.servo_l = 8'(l);
    bus.servo_r = 8'(r);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    int guard;
    guard = 0;
    while (!(m_running && m_pos == p) && guard < 3 * PERIOD) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3 * PERIOD) checkOutput("wait_pos_timeout", guard, 0);
  endtask

  // Reference: frame position and applied commands, updated at each clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_running = 1'b0;
      m_pos     = 0;
      m_app_l   = 0;
      m_app_r   = 0;
    end else if (!m_running || m_pos == PERIOD - 1) begin
      m_running = 1'b1;
      m_pos     = 0;
      m_app_l   = next_applied(int'(bus.servo_l), m_app_l);
      m_app_r   = next_applied(int'(bus.servo_r), m_app_r);
    end else begin
      m_pos++;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("frame_start", int'(bus.frame_start), int'(m_running && m_pos == 0));
      checkOutput("pwm_l", int'(bus.pwm_l), int'(m_running && m_pos < pulse_w(m_app_l)));
      checkOutput("pwm_r", int'(bus.pwm_r), int'(m_running && m_pos < pulse_w(m_app_r)));
      checkOutput("applied_l", int'(bus.applied_l), m_app_l);
      checkOutput("applied_r", int'(bus.applied_r), m_app_r);

      // Whole-frame pulse length, measured independently of the per-cycle comparison.
      if (!m_running) begin
        meas_valid = 1'b0;
      end else begin
        if (m_pos == 0) begin
          if (meas_valid) begin
            checkOutput("len_l", hi_l, exp_len_l);
            checkOutput("len_r", hi_r, exp_len_r);
          end
          meas_valid = 1'b1;
          hi_l       = 0;
          hi_r       = 0;
          exp_len_l  = pulse_w(m_app_l);
          exp_len_r  = pulse_w(m_app_r);
        end
        hi_l += int'(bus.pwm_l);
        hi_r += int'(bus.pwm_r);
      end
    end
  end

  initial begin
    applyStimulus(0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    cycles(10);

    rst_n = 1'b1;
    cycles(2 * PERIOD + 5);

    applyStimulus(155, 137);
    cycles(3 * PERIOD);
    applyStimulus(255, 0);
    cycles(2 * PERIOD);
    applyStimulus(1, 0);
    cycles(2 * PERIOD);

    applyStimulus(155, 137);
    cycles(PERIOD);
    wait_pos(100);
    applyStimulus(0, 137);
    wait_pos(0);
    wait_pos(900);
    applyStimulus(155, 137);
    cycles(2 * PERIOD);

    wait_pos(100);
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2 * PERIOD + 5);

    applyStimulus(0, 0);
    cycles(11 * PERIOD);
    applyStimulus(155, 40);
    cycles(11 * PERIOD);
    applyStimulus(0, 0);
    cycles(11 * PERIOD);

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       applyStimulus(255, int'($urandom_range(0, 1)));
        default: applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      endcase
      cycles(int'($urandom_range(1, PERIOD)));
      if ($urandom_range(0, 5) == 0) begin
        rst_n = 1'b0;
        cycles(int'($urandom_range(1, 4)));
        rst_n = 1'b1;
      end
    end
    cycles(PERIOD + 2);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_pwm.md
# servo_pwm

Two-channel servo pulse generator downstream of the line-follower servo command stage. It consumes the 8-bit left/right speed commands and produces the two drive pulses for the continuous-rotation servos: one pulse per fixed frame, with width set by the command. Commands are sampled once per frame into shadow registers, so a pulse in progress is never truncated or stretched. Outputs go straight to the Pmod pins.

## Interface
Parameters:
- `PERIOD_CYC`, 2_000_000: frame length in clk cycles (20 ms at 100 MHz).
- `MIN_CYC`, 100_000: base pulse width for command 1 (minus one `STEP_CYC`).
- `STEP_CYC`, 392: added cycles per command LSB.
- `SLEW_STEP`, 16: max change of the applied command per frame. Used only with `SERVO_PWM_SLEW_EN`.
- Constraint: `MIN_CYC + 255*STEP_CYC < PERIOD_CYC`. All width arithmetic is done in 32 bits.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: synchronous, active-low reset.
- `servo_l` in 8: left speed command; 0 = off.
- `servo_r` in 8: right speed command; 0 = off.
- `pwm_l` out 1: left servo pulse, registered.
- `pwm_r` out 1: right servo pulse, registered.
- `frame_start` out 1: one-cycle strobe marking the first cycle of each frame.
- `applied_l` out 8: command currently driving the left pulse width.
- `applied_r` out 8: command currently driving the right pulse width.

## Operation
- Frame counter `cnt` counts 0 to `PERIOD_CYC-1`, then wraps to 0. Each frame lasts exactly `PERIOD_CYC` cycles.
- **Frame edge:** the clock edge at which `cnt` enters 0, or the first edge with `rst_n` sampled high after reset. At this edge:
  - `servo_l` and `servo_r` are sampled.
  - `applied_l` and `applied_r` are updated.
  - `frame_start` is set high for one cycle.
- Pulse width for applied value `a`:
  - `W(a) = 0` if `a == 0`.
  - `W(a) = MIN_CYC + a*STEP_CYC` otherwise.
- In each frame, `pwm_x` is high for exactly `W(applied_x)` cycles, starting in the same cycle as `frame_start`. It is low for the rest of the frame.
- `a == 0` means no pulse at all for that frame, so the servo is unpowered.
- Input changes mid-frame have no effect until the next frame edge. Inputs are not required to be stable outside that edge.
- The two channels are independent and share only `cnt`.
- Reset (`rst_n` low at an edge), including mid-pulse:
  - `cnt`, `applied_l`, `applied_r` ← 0.
  - `pwm_l`, `pwm_r`, `frame_start` ← 0 at that same edge.
  - The frame restarts at the first edge with `rst_n` high.

## Timing
- Reset values: `pwm_l = pwm_r = frame_start = 0`, `applied_l = applied_r = 0`.
- Latency from a frame edge to the output change is 0 cycles, because the outputs are the flops loaded at that edge.
- A command sampled at frame edge N appears in frame N. Without slew, it is fully applied in that frame.
- `frame_start` strobes are spaced exactly `PERIOD_CYC` cycles apart.
- The pulse falls at the edge ending cycle `W-1` of the frame. Maximum W still leaves at least 1 low cycle before the next frame.

## Configuration
- `SERVO_PWM_SLEW_EN` defined: at each frame edge, with target `t` = sampled input and current applied value `a`:
  - If `|t - a| <= SLEW_STEP`, then `a` ← `t`.
  - Otherwise `a` ← `a ± SLEW_STEP`, moving toward `t`.
  - Ramp-down to 0 follows the same rule.
  - `applied_x` reflects the ramped value.
- `SERVO_PWM_SLEW_EN` undefined: at each frame edge, `a` ← `t` directly. No `SLEW_STEP` logic is synthesized.

## Test plan
All scenarios use `PERIOD_CYC=1000`, `MIN_CYC=50`, `STEP_CYC=1`.
- **Reset and idle:** hold `rst_n` low for 10 cycles, then release with `servo_l=servo_r=0` → all outputs 0 during reset; `frame_start` pulses every 1000 cycles; `pwm_l`/`pwm_r` never go high.
- **Nominal commands:** `servo_l=155`, `servo_r=137` → `pwm_l` high 205 cycles and `pwm_r` high 187 cycles, both rising with `frame_start`, every frame; `applied_l=155`, `applied_r=137`.
- **Bounds:** `servo_l=255` → 305-cycle pulse; `servo_l=1` → 51-cycle pulse; `servo_r=0` → no pulse.
- **Mid-frame change:** `servo_l` 155→0 at frame cycle 100 → current pulse still 205 cycles; next frame has no pulse; change back at cycle 900 → 205-cycle pulse in the following frame.
- **Reset mid-pulse:** `rst_n` low at frame cycle 100 with `pwm_l` high → `pwm_l=0` after that edge; after release, the first frame is a full 205-cycle pulse with `frame_start` coincident.
- **Slew (`SERVO_PWM_SLEW_EN`, `SLEW_STEP=16`):** step 0→155 → `applied_l` = 16, 32, …, 144, 155 over 10 frames (pulse 66…194, 205); then 155→0 → 139, 123, …, 11, 0 over 10 frames.
